// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Select sequencer and capture stage for an 8:1 multiplexer. A start request
// steps the select lines S2..S0 through channels 0..7. The block waits SETTLE
// cycles on each channel and then samples the mux output Z into bit <sel> of a
// capture buffer. The finished byte goes out on DATA with a VALID/READY
// handshake. All outputs come straight from flops.
//
// Parameters:
//   SETTLE  wait cycles per channel before Z is sampled (0..15)
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   START  in   scan request, honoured only while idle
//   BUSY   out  high whenever the sequencer is not idle
//   S2..S0 out  mux select (S2 = MSB)
//   Z      in   mux output, synchronous to CLK
//   DATA   out  captured byte, bit i = Z sampled with select = i
//   VALID  out  DATA available
//   READY  in   consumer accepts DATA
//   PAR    out  even parity of DATA (only with MUX_SCAN_PARITY_EN)
//
// Optional feature macro: MUX_SCAN_PARITY_EN adds the registered PAR output.
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  input  logic       Z,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       PAR
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  // XOR of all data bits; the result is 0 when the byte has an even number of ones.
  function automatic logic even_parity(input logic [7:0] value);
    return ^value;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] sel_q,   sel_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [7:0] cap_q,   cap_d;
  logic [7:0] data_q,  data_d;
  logic       valid_q, valid_d;
  logic       busy_q,  busy_d;
`ifdef MUX_SCAN_PARITY_EN
  logic       par_q,   par_d;
`endif

  // Next-state logic for the sequencer, the capture buffer and the output registers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SCAN;
          sel_d   = 3'd0;
          cnt_d   = SETTLE_CNT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final cycle of this channel: Z is taken only here, so settle glitches are ignored.
          cap_d[sel_q] = Z;
          if (sel_q == 3'd7) begin
            // The published byte must include the bit captured on this edge.
            data_d  = cap_d;
            valid_d = 1'b1;
            state_d = ST_OUT;
          end else begin
            sel_d = sel_q + 3'd1;
            cnt_d = SETTLE_CNT;
          end
        end
      end

      ST_OUT: begin
        if (READY) begin
          valid_d = 1'b0;
          sel_d   = 3'd0;
          cap_d   = 8'h00;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'd0;
        cnt_d   = 4'd0;
        cap_d   = 8'h00;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity follows the next DATA value, so PAR and DATA update on the same edge.
  always_comb begin
    par_d = even_parity(data_d);
  end
`endif

  // State and output registers; reset aborts any scan and drops the partial byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      cap_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign BUSY  = busy_q;
  assign S2    = sel_q[2];
  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign DATA  = data_q;
  assign VALID = valid_q;
`ifdef MUX_SCAN_PARITY_EN
  assign PAR   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//
// Self-checking bench for mux_scan_ctrl. Instance A (SETTLE = 1) gets
// randomized scans. Each scan pushes its expected byte, its VALID cycle and
// its VALID width into a queue, and a negedge monitor pops and compares them.
// Instance B (SETTLE = 0) has START held high. Its outputs are compared cycle
// by cycle against closed-form timing formulas. Both instances share RST.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  localparam int S_A = 1;
  localparam int S_B = 0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       start_a, z_a, ready_a, busy_a, s2_a, s1_a, s0_a, valid_a;
  logic [7:0] data_a;
  logic       start_b, z_b, ready_b, busy_b, s2_b, s1_b, s0_b, valid_b;
  logic [7:0] data_b;
  logic [2:0] sel_a, sel_b;
`ifdef MUX_SCAN_PARITY_EN
  logic       par_a, par_b;
`endif

  assign sel_a = {s2_a, s1_a, s0_a};
  assign sel_b = {s2_b, s1_b, s0_b};

  mux_scan_ctrl #(.SETTLE(S_A)) u_dut_a (
    .CLK(CLK), .RST(RST), .START(start_a), .BUSY(busy_a),
    .S2(s2_a), .S1(s1_a), .S0(s0_a), .Z(z_a),
    .DATA(data_a), .VALID(valid_a), .READY(ready_a)
`ifdef MUX_SCAN_PARITY_EN
    , .PAR(par_a)
`endif
  );

  mux_scan_ctrl #(.SETTLE(S_B)) u_dut_b (
    .CLK(CLK), .RST(RST), .START(start_b), .BUSY(busy_b),
    .S2(s2_b), .S1(s1_b), .S0(s0_b), .Z(z_b),
    .DATA(data_b), .VALID(valid_b), .READY(ready_b)
`ifdef MUX_SCAN_PARITY_EN
    , .PAR(par_b)
`endif
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         due;
    int         width;
  } exp_t;

  exp_t exp_q[$];

  // Monitor for instance A: pops an entry when VALID rises, then follows the hold period.
  logic vprev = 1'b0;
  exp_t cur;
  int   wcnt = 0;
  always @(negedge CLK) begin
    if (valid_a && !vprev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check("data", int'(data_a), int'(cur.data));
        check("valid_latency", cyc, cur.due);
        wcnt = 1;
      end
    end else if (valid_a) begin
      wcnt++;
      check("data_hold", int'(data_a), int'(cur.data));
    end
    if (valid_a) begin
      check("sel_out", int'(sel_a), 7);
      check("busy_out", int'(busy_a), 1);
`ifdef MUX_SCAN_PARITY_EN
      check("par", int'(par_a), int'(^cur.data));
`endif
    end
    if (!valid_a && vprev) begin
      check("valid_width", wcnt, cur.width);
      check("busy_after", int'(busy_a), 0);
    end
    vprev = valid_a;
  end

  // One scan on instance A, started from idle at a negedge. If use_pat is set,
  // Z carries pat[i] on the sampling cycle of channel i. Otherwise Z is random,
  // and it is random on every settle cycle in both cases. READY stays low for
  // w cycles after VALID rises.
  task automatic scan_a(input logic [7:0] pat, input bit use_pat, input int w);
    logic [7:0] e;
    int         k;
    exp_t       x;
    e       = 8'h00;
    ready_a = (w == 0);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    k = cyc;
    check("busy_start", int'(busy_a), 1);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j <= S_A; j++) begin
        check("sel_scan", int'(sel_a), i);
        if (j == S_A && use_pat) z_a = pat[i];
        else                     z_a = 1'($urandom);
        if (j == S_A) e[i] = z_a;
        if (i == 7 && j == S_A) begin
          x.data  = e;
          x.due   = k + 8 * (S_A + 1);
          x.width = w + 1;
          exp_q.push_back(x);
        end
        @(negedge CLK);
      end
    end
    repeat (w) @(negedge CLK);
    ready_a = 1'b1;
    @(negedge CLK);
    ready_a = 1'($urandom);
  endtask

  logic [7:0] pat3c;
  int         m, e_valid, e_busy, e_sel;

  initial begin
    RST = 1'b1;
    start_a = 1'b0; z_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; z_b = 1'b0; ready_b = 1'b0;

    // Inputs toggle while reset is held; every output must stay at 0.
    repeat (5) begin
      @(negedge CLK);
      start_a = 1'($urandom); z_a = 1'($urandom); ready_a = 1'($urandom);
      start_b = 1'($urandom); z_b = 1'($urandom); ready_b = 1'($urandom);
      #1;
      check("rst_busy", int'(busy_a | busy_b), 0);
      check("rst_sel", int'(sel_a | sel_b), 0);
      check("rst_valid", int'(valid_a | valid_b), 0);
      check("rst_data", int'(data_a | data_b), 0);
`ifdef MUX_SCAN_PARITY_EN
      check("rst_par", int'(par_a | par_b), 0);
`endif
    end
    @(negedge CLK);
    RST = 1'b0;
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    @(negedge CLK);

    // Directed scans: a basic pass, backpressure, and both parity cases.
    scan_a(8'hA5, 1'b1, 0);
    scan_a(8'hA5, 1'b1, 5);
    scan_a(8'h07, 1'b1, 2);

    // Random scans with random backpressure and random idle gaps.
    repeat (8) begin
      scan_a(8'($urandom), 1'b0, $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // SETTLE = 0 with START held high: back-to-back scans of 8'h3C.
    // Scans are 10 cycles apart, with VALID at j%10 = 9 and the single idle
    // cycle at j%10 = 0.
    pat3c   = 8'h3C;
    ready_b = 1'b1;
    z_b     = pat3c[sel_b];
    start_b = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      @(negedge CLK);
      m       = j % 10;
      e_valid = (m == 9 && j <= 29) ? 1 : 0;
      e_busy  = (j < 30 && m != 0) ? 1 : 0;
      if (j >= 30)                e_sel = 0;
      else if (m >= 1 && m <= 8)  e_sel = m - 1;
      else if (m == 9)            e_sel = 7;
      else                        e_sel = 0;
      check("b_valid", int'(valid_b), e_valid);
      check("b_busy", int'(busy_b), e_busy);
      check("b_sel", int'(sel_b), e_sel);
      if (valid_b) check("b_data", int'(data_b), 8'h3C);
      if (j == 25) start_b = 1'b0;
      z_b = pat3c[sel_b];
    end

    // A reset after channel 3 has been sampled must abort the scan at once.
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (8) begin
      z_a = 1'($urandom);
      @(negedge CLK);
    end
    check("sel_before_rst", int'(sel_a), 4);
    RST = 1'b1;
    #1;
    check("abort_busy", int'(busy_a), 0);
    check("abort_sel", int'(sel_a), 0);
    check("abort_valid", int'(valid_a), 0);
    check("abort_data", int'(data_a), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_after_rst", int'(busy_a | valid_a), 0);

    scan_a(8'hFF, 1'b1, 0);

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Upstream select sequencer and capture stage for the 8:1 multiplexer. On a start request it steps the mux select lines S2..S0 through channels 0 to 7, waits a programmable settle time on each channel, and samples the mux output Z. It assembles the eight samples into one byte and presents it through a valid/ready handshake. The block drives the mux select inputs directly and consumes its Z output.

## Interface

Parameters:
- SETTLE, default 1: wait cycles per channel before Z is sampled; legal range 0..15 (4-bit counter).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- START  in  1  scan request; sampled only in IDLE.
- BUSY  out  1  high in any state other than IDLE.
- S2  out  1  mux select, MSB.
- S1  out  1  mux select.
- S0  out  1  mux select, LSB.
- Z  in  1  mux output; treated as synchronous to CLK.
- DATA  out  8  captured byte; bit i is Z sampled while select = i.
- VALID  out  1  DATA is available.
- READY  in  1  consumer accepts DATA.
- PAR  out  1  even parity of DATA; present only with MUX_SCAN_PARITY_EN.

## Operation

- States:
  - IDLE: waits for a start request.
  - SCAN: steps through the channels.
  - OUT: holds the result until the consumer accepts it.
- Select lines S2..S0 form a 3-bit index `sel`.
- Channel counter `cnt` is 4 bits wide.
- IDLE:
  - sel = 0, VALID = 0.
  - If START = 1 at an edge, go to SCAN with sel = 0 and cnt = SETTLE.
- SCAN, on each edge:
  - If cnt != 0: decrement cnt.
  - Else: write Z into capture buffer bit sel.
    - If sel = 7: load DATA from the buffer (including the bit captured this edge), set VALID = 1, go to OUT. sel stays 7.
    - Else: increment sel and reload cnt = SETTLE.
- OUT:
  - DATA and sel are held.
  - On an edge with READY = 1: clear VALID, set sel = 0, clear the capture buffer, go to IDLE.
  - DATA keeps its last value until the next completed scan.
- START is ignored in SCAN and OUT; requests are not queued.
- Consecutive scans are separated by at least one IDLE cycle.
- Z is sampled only at the final cycle of each channel. Glitches during the settle cycles are ignored.

## Timing

- Reset value of every output: BUSY = 0, S2 = S1 = S0 = 0, DATA = 8'h00, VALID = 0, PAR = 0. Capture buffer and cnt are 0, state is IDLE.
- Reset asserted mid-scan or in OUT aborts immediately. No VALID is produced and the partial byte is discarded.
- If START is accepted at edge k:
  - BUSY and the new sel value appear after edge k.
  - Channel i is sampled at edge k + (i+1)(SETTLE+1).
  - VALID rises after edge k + 8(SETTLE+1). For SETTLE = 1 this is 16 cycles.
- Each select value is held for exactly SETTLE+1 cycles.
- If READY is already high when VALID rises, the transfer completes at the very next edge, so VALID is high for 1 cycle.
- BUSY falls after the handshake edge. The earliest next START acceptance is the following edge.
- All outputs are registered; there is no combinational path from START, Z or READY to any output.

## Configuration

- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - Output PAR exists and equals the XOR of the DATA bits.
  - PAR is registered and updates on the same edge as DATA.
  - Reset value of PAR is 0.
- Undefined: PAR port and its logic are absent. All other behaviour is identical.

## Test plan

- Reset: hold RST high, toggle START, Z and READY → all outputs stay 0 and BUSY = 0.
- Basic scan: SETTLE = 1, Z driven as bit sel of 8'hA5, READY = 1, single START pulse → sel steps 0..7 every 2 cycles, VALID high 16 cycles after the START edge, DATA = 8'hA5, VALID high for 1 cycle.
- Backpressure: READY = 0 for 5 cycles after VALID rises → DATA = 8'hA5, VALID = 1 and sel = 7 stable throughout; raising READY → VALID and BUSY clear after the next edge.
- Ignored start and zero settle: START held high through a scan with SETTLE = 0 and Z = bit sel of 8'h3C → one result, DATA = 8'h3C after 8 cycles; the next scan starts only after one IDLE cycle.
- Mid-scan reset: RST pulsed after channel 3 is sampled → all outputs 0 immediately, no VALID; a fresh scan with Z = 1 gives DATA = 8'hFF.
- Parity: MUX_SCAN_PARITY_EN defined, scans of 8'hA5 and 8'h07 → PAR = 0, then PAR = 1.
